// File: rtl/arbitration_receiver.sv
// Receive-side link arbiter: classifies decoded commas, raises credit/ack events,
// and reframes START/DATA/END symbols into a checked flit stream for the RX FIFO.

package phy_types_pkg;
    typedef enum logic [2:0] {
        NADA_SEL,
        START_PACKET_SEL,
        END_PACKET_SEL,
        DATA_SEL,
        GRTCRED0_SEL,
        GRTCRED1_SEL,
        ACK_SEL
    } comma_sel_t;
endpackage

package chiplet_types_pkg;
    typedef logic [31:0] flit_t;

    // Header flit carries the packet length in flits (header included) in its low 9 bits.
    function automatic logic [8:0] expected_num_flits(input flit_t hdr);
        return hdr[8:0];
    endfunction
endpackage

module arbitration_receiver
    import phy_types_pkg::*;
    import chiplet_types_pkg::*;
#(
    parameter int unsigned MAX_FLITS = 511
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       dec_valid,
    input  comma_sel_t dec_comma_sel,
    input  flit_t      dec_flit,
    input  flit_t      dec_header,
    input  logic       dec_err,
    input  logic       fifo_full,
    input  logic       err_clear,
    output flit_t      flit_out,
    output logic       flit_wen,
    output logic       pkt_last,
    output logic       pkt_abort,
    output logic       grtcred0_rcvd,
    output logic       grtcred1_rcvd,
    output logic       ack_rcvd,
    output flit_t      ack_header,
    output logic       err_framing,
    output logic       err_overflow,
    output logic       err_code
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

    state_t     state, state_n;
    logic [8:0] count, count_n;
    logic [8:0] size, size_n;
    logic [9:0] hdr_size;
    flit_t      flit_n, ack_header_n;
    logic       wen_n, last_n, abort_n, g0_n, g1_n, ack_n;
    logic       new_framing, new_overflow, new_code;
    logic       in_packet;

    always_comb begin
        state_n      = state;
        count_n      = count;
        size_n       = size;
        flit_n       = flit_out;
        ack_header_n = ack_header;
        wen_n        = 1'b0;
        last_n       = 1'b0;
        abort_n      = 1'b0;
        g0_n         = 1'b0;
        g1_n         = 1'b0;
        ack_n        = 1'b0;
        new_framing  = 1'b0;
        new_overflow = 1'b0;
        new_code     = 1'b0;
        // Extra top bit keeps the upper-bound check meaningful for any MAX_FLITS.
        hdr_size     = {1'b0, expected_num_flits(dec_flit)};
        in_packet    = (state == HEADER) || (state == PAYLOAD);

        if (dec_valid) begin
            if (dec_err) begin
                new_code = 1'b1;
                if (in_packet) begin
                    abort_n = 1'b1;
                    state_n = DISCARD;
                end
            end else begin
                case (dec_comma_sel)
                    GRTCRED0_SEL: g0_n = 1'b1;
                    GRTCRED1_SEL: g1_n = 1'b1;
                    ACK_SEL: begin
                        ack_n        = 1'b1;
                        ack_header_n = dec_header;
                    end
                    START_PACKET_SEL: begin
                        if (in_packet) begin
                            new_framing = 1'b1;
                            abort_n     = 1'b1;
                        end
                        state_n = HEADER;
                        count_n = '0;
                    end
                    DATA_SEL: begin
                        case (state)
                            IDLE: new_framing = 1'b1;
                            HEADER: begin
                                if (hdr_size == '0 || hdr_size > 10'(MAX_FLITS)) begin
                                    new_framing = 1'b1;
                                    abort_n     = 1'b1;
                                    state_n     = DISCARD;
                                end else if (fifo_full) begin
                                    new_overflow = 1'b1;
                                    abort_n      = 1'b1;
                                    state_n      = DISCARD;
                                end else begin
                                    wen_n   = 1'b1;
                                    flit_n  = dec_flit;
                                    count_n = 9'd1;
                                    size_n  = hdr_size[8:0];
                                    last_n  = (hdr_size == 10'd1);
                                    state_n = PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                if (count == size) begin
                                    new_framing = 1'b1;
                                    abort_n     = 1'b1;
                                    state_n     = DISCARD;
                                end else if (fifo_full) begin
                                    new_overflow = 1'b1;
                                    abort_n      = 1'b1;
                                    state_n      = DISCARD;
                                end else begin
                                    wen_n   = 1'b1;
                                    flit_n  = dec_flit;
                                    count_n = count + 9'd1;
                                    last_n  = (count + 9'd1 == size);
                                end
                            end
                            default: ;
                        endcase
                    end
                    END_PACKET_SEL: begin
                        case (state)
                            IDLE: new_framing = 1'b1;
                            HEADER: begin
                                new_framing = 1'b1;
                                abort_n     = 1'b1;
                                state_n     = IDLE;
                            end
                            PAYLOAD: begin
                                if (count != size) begin
                                    new_framing = 1'b1;
                                    abort_n     = 1'b1;
                                end
                                state_n = IDLE;
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= IDLE;
            count         <= '0;
            size          <= '0;
            flit_out      <= '0;
            flit_wen      <= 1'b0;
            pkt_last      <= 1'b0;
            pkt_abort     <= 1'b0;
            grtcred0_rcvd <= 1'b0;
            grtcred1_rcvd <= 1'b0;
            ack_rcvd      <= 1'b0;
            ack_header    <= '0;
            err_framing   <= 1'b0;
            err_overflow  <= 1'b0;
            err_code      <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            size          <= size_n;
            flit_out      <= flit_n;
            flit_wen      <= wen_n;
            pkt_last      <= last_n;
            pkt_abort     <= abort_n;
            grtcred0_rcvd <= g0_n;
            grtcred1_rcvd <= g1_n;
            ack_rcvd      <= ack_n;
            ack_header    <= ack_header_n;
            // A fresh error in the clearing cycle keeps its bit set.
            err_framing   <= (err_framing  & ~err_clear) | new_framing;
            err_overflow  <= (err_overflow & ~err_clear) | new_overflow;
            err_code      <= (err_code     & ~err_clear) | new_code;
        end
    end

endmodule

// File: tb/tb_arbitration_receiver.sv
// Directed vector bench for arbitration_receiver: framing, credits, overflow, error and reset cases.

module tb_arbitration_receiver;
    import phy_types_pkg::*;
    import chiplet_types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       dec_valid;
    comma_sel_t dec_comma_sel;
    flit_t      dec_flit;
    flit_t      dec_header;
    logic       dec_err;
    logic       fifo_full;
    logic       err_clear;
    flit_t      flit_out;
    logic       flit_wen;
    logic       pkt_last;
    logic       pkt_abort;
    logic       grtcred0_rcvd;
    logic       grtcred1_rcvd;
    logic       ack_rcvd;
    flit_t      ack_header;
    logic       err_framing;
    logic       err_overflow;
    logic       err_code;

    arbitration_receiver #(.MAX_FLITS(511)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .dec_valid     (dec_valid),
        .dec_comma_sel (dec_comma_sel),
        .dec_flit      (dec_flit),
        .dec_header    (dec_header),
        .dec_err       (dec_err),
        .fifo_full     (fifo_full),
        .err_clear     (err_clear),
        .flit_out      (flit_out),
        .flit_wen      (flit_wen),
        .pkt_last      (pkt_last),
        .pkt_abort     (pkt_abort),
        .grtcred0_rcvd (grtcred0_rcvd),
        .grtcred1_rcvd (grtcred1_rcvd),
        .ack_rcvd      (ack_rcvd),
        .ack_header    (ack_header),
        .err_framing   (err_framing),
        .err_overflow  (err_overflow),
        .err_code      (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected-output bits: {wen, last, abort, g0, g1, ack, framing, overflow, code}
    localparam logic [8:0] Z  = 9'h000;
    localparam logic [8:0] W  = 9'h100;
    localparam logic [8:0] L  = 9'h080;
    localparam logic [8:0] A  = 9'h040;
    localparam logic [8:0] G0 = 9'h020;
    localparam logic [8:0] G1 = 9'h010;
    localparam logic [8:0] K  = 9'h008;
    localparam logic [8:0] EF = 9'h004;
    localparam logic [8:0] EO = 9'h002;
    localparam logic [8:0] EC = 9'h001;

    typedef struct {
        string      name;
        logic       v;
        comma_sel_t sel;
        flit_t      flit;
        logic       err;
        logic       full;
        logic       clr;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string n, input logic v, input comma_sel_t s,
                                input flit_t f, input logic e, input logic fu,
                                input logic c, input logic [8:0] x);
        vec_t t;
        t.name = n; t.v = v; t.sel = s; t.flit = f;
        t.err = e; t.full = fu; t.clr = c; t.exp = x;
        return t;
    endfunction

    function automatic logic [8:0] outs();
        return {flit_wen, pkt_last, pkt_abort, grtcred0_rcvd, grtcred1_rcvd,
                ack_rcvd, err_framing, err_overflow, err_code};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    task automatic apply(input vec_t t);
        dec_valid     = t.v;
        dec_comma_sel = t.sel;
        dec_flit      = t.flit;
        dec_header    = t.flit;
        dec_err       = t.err;
        fifo_full     = t.full;
        err_clear     = t.clr;
        @(posedge CLK);
        #1;
        check(t.name, 32'(outs()), 32'(t.exp));
        if (t.exp[8]) check({t.name, "_flit"}, flit_out, t.flit);
        if (t.exp[3]) check({t.name, "_ackhdr"}, ack_header, t.flit);
    endtask

    task automatic check_all_zero(input string n);
        check({n, "_outs"}, 32'(outs()), 32'(Z));
        check({n, "_flit"}, flit_out, '0);
        check({n, "_ackhdr"}, ack_header, '0);
    endtask

    initial begin
        nRST = 1'b0;
        dec_valid = 1'b0; dec_comma_sel = NADA_SEL; dec_flit = '0; dec_header = '0;
        dec_err = 1'b0; fifo_full = 1'b0; err_clear = 1'b0;

        // clean 3-flit packet, then DATA in IDLE proves the return to IDLE
        tbl.push_back(mk("c3_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("c3_hdr", 1, DATA_SEL, 32'h1000_0003, 0, 0, 0, W));
        tbl.push_back(mk("c3_d1", 1, DATA_SEL, 32'hD000_0001, 0, 0, 0, W));
        tbl.push_back(mk("c3_d2", 1, DATA_SEL, 32'hD000_0002, 0, 0, 0, W | L));
        tbl.push_back(mk("c3_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("c3_idle_data", 1, DATA_SEL, 32'hD000_0003, 0, 0, 0, EF));
        tbl.push_back(mk("clr_a", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // credits and ack interleaved in a packet; invalid and NADA symbols ignored
        tbl.push_back(mk("cr_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("cr_hdr", 1, DATA_SEL, 32'h2000_0003, 0, 0, 0, W));
        tbl.push_back(mk("cr_g0", 1, GRTCRED0_SEL, 32'h0, 0, 0, 0, G0));
        tbl.push_back(mk("cr_g1", 1, GRTCRED1_SEL, 32'h0, 0, 0, 0, G1));
        tbl.push_back(mk("cr_nada", 1, NADA_SEL, 32'hFFFF_FFFF, 0, 0, 0, Z));
        tbl.push_back(mk("cr_invalid", 0, DATA_SEL, 32'hEEEE_0001, 1, 1, 0, Z));
        tbl.push_back(mk("cr_d1", 1, DATA_SEL, 32'hD100_0001, 0, 0, 0, W));
        tbl.push_back(mk("cr_ack", 1, ACK_SEL, 32'h0000_00A5, 0, 0, 0, K));
        tbl.push_back(mk("cr_d2", 1, DATA_SEL, 32'hD100_0002, 0, 0, 0, W | L));
        tbl.push_back(mk("cr_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        // short packet: END after 2 of 4
        tbl.push_back(mk("sp_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("sp_hdr", 1, DATA_SEL, 32'h3000_0004, 0, 0, 0, W));
        tbl.push_back(mk("sp_d1", 1, DATA_SEL, 32'hD200_0001, 0, 0, 0, W));
        tbl.push_back(mk("sp_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, A | EF));
        tbl.push_back(mk("sp_g0", 1, GRTCRED0_SEL, 32'h0, 0, 0, 0, G0 | EF));
        tbl.push_back(mk("clr_b", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // overflow on 2nd flit of size-5 packet, then a clean packet
        tbl.push_back(mk("ov_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("ov_hdr", 1, DATA_SEL, 32'h4000_0005, 0, 0, 0, W));
        tbl.push_back(mk("ov_d1_full", 1, DATA_SEL, 32'hD300_0001, 0, 1, 0, A | EO));
        tbl.push_back(mk("ov_d2_drop", 1, DATA_SEL, 32'hD300_0002, 0, 0, 0, EO));
        tbl.push_back(mk("ov_d3_drop", 1, DATA_SEL, 32'hD300_0003, 0, 0, 0, EO));
        tbl.push_back(mk("ov_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EO));
        tbl.push_back(mk("ov_idle_data", 1, DATA_SEL, 32'hD300_0004, 0, 0, 0, EO | EF));
        tbl.push_back(mk("clr_c", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        tbl.push_back(mk("nx_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("nx_hdr", 1, DATA_SEL, 32'h5000_0002, 0, 0, 0, W));
        tbl.push_back(mk("nx_d1", 1, DATA_SEL, 32'hD400_0001, 0, 0, 0, W | L));
        tbl.push_back(mk("nx_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        // START during PAYLOAD restarts from the new header
        tbl.push_back(mk("rs_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("rs_hdr", 1, DATA_SEL, 32'h6000_0004, 0, 0, 0, W));
        tbl.push_back(mk("rs_d1", 1, DATA_SEL, 32'hD500_0001, 0, 0, 0, W));
        tbl.push_back(mk("rs_start2", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, A | EF));
        tbl.push_back(mk("rs_hdr2", 1, DATA_SEL, 32'h6100_0002, 0, 0, 0, W | EF));
        tbl.push_back(mk("rs_d2", 1, DATA_SEL, 32'hD500_0002, 0, 0, 0, W | L | EF));
        tbl.push_back(mk("rs_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EF));
        // code error with err_clear: framing clears, code stays set
        tbl.push_back(mk("ec_with_clr", 1, DATA_SEL, 32'h0, 1, 0, 1, EC));
        tbl.push_back(mk("clr_d", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // code error mid-packet
        tbl.push_back(mk("ce_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("ce_hdr", 1, DATA_SEL, 32'h7000_0003, 0, 0, 0, W));
        tbl.push_back(mk("ce_err", 1, DATA_SEL, 32'hD600_0001, 1, 0, 0, A | EC));
        tbl.push_back(mk("ce_d_drop", 1, DATA_SEL, 32'hD600_0002, 0, 0, 0, EC));
        tbl.push_back(mk("ce_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EC));
        tbl.push_back(mk("clr_e", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // size 0 header
        tbl.push_back(mk("z_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("z_hdr", 1, DATA_SEL, 32'h8000_0000, 0, 0, 0, A | EF));
        tbl.push_back(mk("z_d_drop", 1, DATA_SEL, 32'hD700_0001, 0, 0, 0, EF));
        tbl.push_back(mk("z_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EF));
        tbl.push_back(mk("clr_f", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // size 1: clean, then one DATA too many
        tbl.push_back(mk("s1_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("s1_hdr", 1, DATA_SEL, 32'h9000_0001, 0, 0, 0, W | L));
        tbl.push_back(mk("s1_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("s1x_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("s1x_hdr", 1, DATA_SEL, 32'h9100_0001, 0, 0, 0, W | L));
        tbl.push_back(mk("s1x_extra", 1, DATA_SEL, 32'hD800_0001, 0, 0, 0, A | EF));
        tbl.push_back(mk("s1x_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EF));
        tbl.push_back(mk("clr_g", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // END in HEADER, then END in IDLE (framing, no abort)
        tbl.push_back(mk("eh_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("eh_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, A | EF));
        tbl.push_back(mk("eh_idle_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EF));
        tbl.push_back(mk("clr_h", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // largest legal size accepted; fifo_full on the header itself
        tbl.push_back(mk("mx_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        tbl.push_back(mk("mx_hdr", 1, DATA_SEL, 32'hA000_01FF, 0, 0, 0, W));
        tbl.push_back(mk("mx_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, A | EF));
        tbl.push_back(mk("fh_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 1, Z));
        tbl.push_back(mk("fh_hdr_full", 1, DATA_SEL, 32'hB000_0003, 0, 1, 0, A | EO));
        tbl.push_back(mk("fh_end", 1, END_PACKET_SEL, 32'h0, 0, 0, 0, EO));
        tbl.push_back(mk("clr_i", 0, NADA_SEL, 32'h0, 0, 0, 1, Z));
        // leave a nonzero ack_header for the reset sequence to clear
        tbl.push_back(mk("pre_rst_ack", 1, ACK_SEL, 32'h0000_005A, 0, 0, 0, K));

        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        nRST = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // reset mid-PAYLOAD
        apply(mk("rm_start", 1, START_PACKET_SEL, 32'h0, 0, 0, 0, Z));
        apply(mk("rm_hdr", 1, DATA_SEL, 32'hC000_0003, 0, 0, 0, W));
        nRST = 1'b0;
        dec_valid = 1'b1; dec_comma_sel = DATA_SEL; dec_flit = 32'hC100_0001;
        @(posedge CLK);
        #1;
        check_all_zero("rm_reset");
        nRST = 1'b1;
        apply(mk("rm_data_after", 1, DATA_SEL, 32'hC100_0002, 0, 0, 0, EF));

        dec_valid = 1'b0;
        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
